// File: rtl/cim_inst_queue_pkg.sv
// Shared widths, field layout helpers and the fixed 32-bit instruction format for the CIM instruction queue.
// Address range checking is enabled by defining CIM_ADDR_CHECK_EN.
package cim_inst_queue_pkg;

    localparam int CIM_OP_WIDTH      = 5;
    localparam int CIM_ADDR_WIDTH    = 9;
    localparam int CIM_ADDRESS_DEPTH = 512;
    localparam int CIM_INST_WIDTH    = CIM_OP_WIDTH + 3 * CIM_ADDR_WIDTH;

    typedef enum logic [1:0] {
        FIELD_D1 = 2'd0,
        FIELD_S2 = 2'd1,
        FIELD_S1 = 2'd2,
        FIELD_OP = 2'd3
    } cim_field_e;

    // Fixed layout kept for the default 5/9-bit configuration
    typedef struct packed {
        logic [CIM_OP_WIDTH-1:0]   op;
        logic [CIM_ADDR_WIDTH-1:0] s1;
        logic [CIM_ADDR_WIDTH-1:0] s2;
        logic [CIM_ADDR_WIDTH-1:0] d1;
    } cim_inst_t;

    localparam int CIM_OP_MSB = 31;
    localparam int CIM_S1_MSB = 26;
    localparam int CIM_S2_MSB = 17;
    localparam int CIM_D1_MSB = 8;

    function automatic int cim_inst_width(int op_w, int addr_w);
        return op_w + 3 * addr_w;
    endfunction

    function automatic int cim_field_lsb(cim_field_e field, int addr_w);
        return int'(field) * addr_w;
    endfunction

endpackage

// File: rtl/cim_inst_queue_if.sv
// Instruction intake and decoded-output handshakes of the CIM instruction queue.
interface cim_inst_queue_if
    import cim_inst_queue_pkg::*;
#(
    parameter int OP_WIDTH   = CIM_OP_WIDTH,
    parameter int ADDR_WIDTH = CIM_ADDR_WIDTH
);
    localparam int INST_WIDTH = cim_inst_width(OP_WIDTH, ADDR_WIDTH);

    logic                  in_valid;
    logic                  in_ready;
    logic [INST_WIDTH-1:0] in_inst;
    logic                  out_valid;
    logic                  out_ready;
    logic [OP_WIDTH-1:0]   out_op;
    logic [ADDR_WIDTH-1:0] out_s1;
    logic [ADDR_WIDTH-1:0] out_s2;
    logic [ADDR_WIDTH-1:0] out_d1;

    modport master (
        output in_valid, in_inst, out_ready,
        input  in_ready, out_valid, out_op, out_s1, out_s2, out_d1
    );

    modport slave (
        input  in_valid, in_inst, out_ready,
        output in_ready, out_valid, out_op, out_s1, out_s2, out_d1
    );

endinterface

// File: rtl/cim_sync_fifo.sv
// Generic first-word-fall-through synchronous FIFO with flush and occupancy output.
module cim_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    // Extra MSB on each pointer tells a full queue from an empty one
    assign level = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]});
    assign rdata = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/cim_inst_queue.sv
// CIM instruction intake: queues packed instructions and presents the decoded head to rw_control.
// Defining CIM_ADDR_CHECK_EN drops instructions whose addresses fall outside the array.
module cim_inst_queue
    import cim_inst_queue_pkg::*;
#(
    parameter int OP_WIDTH   = CIM_OP_WIDTH,
    parameter int ADDR_WIDTH = CIM_ADDR_WIDTH,
    parameter int CIM_DEPTH  = CIM_ADDRESS_DEPTH,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    cim_inst_queue_if.slave               bus,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          err_addr,
    output logic [15:0]                   err_count
);
    localparam int INST_WIDTH = cim_inst_width(OP_WIDTH, ADDR_WIDTH);
    localparam int OP_LSB     = cim_field_lsb(FIELD_OP, ADDR_WIDTH);
    localparam int S1_LSB     = cim_field_lsb(FIELD_S1, ADDR_WIDTH);
    localparam int S2_LSB     = cim_field_lsb(FIELD_S2, ADDR_WIDTH);
    localparam int D1_LSB     = cim_field_lsb(FIELD_D1, ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] ADDR_LIM = (ADDR_WIDTH+1)'(CIM_DEPTH);

    logic                  ready_en;
    logic                  accept;
    logic                  push;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic [INST_WIDTH-1:0] head;

    // Holds in_ready low through reset and until the first edge after release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ready_en <= 1'b0;
        else     ready_en <= 1'b1;
    end

    assign bus.in_ready = ready_en && !fifo_full;
    assign accept       = bus.in_valid && bus.in_ready && !flush;

`ifdef CIM_ADDR_CHECK_EN
    logic addr_bad;
    logic err_pulse;
    logic [15:0] err_cnt;

    assign addr_bad = ({1'b0, bus.in_inst[S1_LSB +: ADDR_WIDTH]} >= ADDR_LIM) ||
                      ({1'b0, bus.in_inst[S2_LSB +: ADDR_WIDTH]} >= ADDR_LIM) ||
                      ({1'b0, bus.in_inst[D1_LSB +: ADDR_WIDTH]} >= ADDR_LIM);
    assign push     = accept && !addr_bad;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_pulse <= 1'b0;
            err_cnt   <= '0;
        end else begin
            err_pulse <= accept && addr_bad;
            if (accept && addr_bad && (err_cnt != 16'hFFFF))
                err_cnt <= err_cnt + 16'd1;
        end
    end

    assign err_addr  = err_pulse;
    assign err_count = err_cnt;
`else
    logic unused_cfg;

    assign push       = accept;
    assign err_addr   = 1'b0;
    assign err_count  = '0;
    assign unused_cfg = ^ADDR_LIM;
`endif

    cim_sync_fifo #(
        .WIDTH (INST_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (push),
        .pop   (bus.out_ready),
        .wdata (bus.in_inst),
        .rdata (head),
        .empty (fifo_empty),
        .full  (fifo_full),
        .level (level)
    );

    assign bus.out_valid = !fifo_empty;
    assign bus.out_op    = fifo_empty ? '0 : head[OP_LSB +: OP_WIDTH];
    assign bus.out_s1    = fifo_empty ? '0 : head[S1_LSB +: ADDR_WIDTH];
    assign bus.out_s2    = fifo_empty ? '0 : head[S2_LSB +: ADDR_WIDTH];
    assign bus.out_d1    = fifo_empty ? '0 : head[D1_LSB +: ADDR_WIDTH];

endmodule

// File: tb/tb_cim_inst_queue.sv
// Directed self-checking bench for cim_inst_queue; the address-check section follows CIM_ADDR_CHECK_EN.
module tb_cim_inst_queue;
    import cim_inst_queue_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [3:0]  level;
    logic        err_addr;
    logic [15:0] err_count;
    int          checks   = 0;
    int          failures = 0;

    cim_inst_queue_if #(.OP_WIDTH(CIM_OP_WIDTH), .ADDR_WIDTH(CIM_ADDR_WIDTH)) bus ();

    cim_inst_queue #(
        .OP_WIDTH   (5),
        .ADDR_WIDTH (9),
        .CIM_DEPTH  (384),
        .FIFO_DEPTH (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .bus       (bus),
        .level     (level),
        .err_addr  (err_addr),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive inputs at the falling edge, let one rising edge pass, return at the next falling edge
    task automatic applyStimulus(input logic v, input logic [31:0] inst, input logic rdy, input logic fl);
        bus.in_valid  = v;
        bus.in_inst   = inst;
        bus.out_ready = rdy;
        flush         = fl;
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] mk(input logic [4:0] op, input logic [8:0] s1,
                                       input logic [8:0] s2, input logic [8:0] d1);
        cim_inst_t t;
        t.op = op;
        t.s1 = s1;
        t.s2 = s2;
        t.d1 = d1;
        return t;
    endfunction

    initial begin
        rst           = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_inst   = '0;
        bus.out_ready = 1'b0;
        #2;
        checkOutput("rst_in_ready", bus.in_ready, 0);
        checkOutput("rst_out_valid", bus.out_valid, 0);
        checkOutput("rst_level", level, 0);
        checkOutput("rst_err_count", err_count, 0);
        checkOutput("rst_err_addr", err_addr, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rel_in_ready_pre", bus.in_ready, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("rel_in_ready", bus.in_ready, 1);

        // Basic push and decode
        applyStimulus(1, 32'h08040A03, 0, 0);
        checkOutput("dec_valid", bus.out_valid, 1);
        checkOutput("dec_op", bus.out_op, 1);
        checkOutput("dec_s1", bus.out_s1, 1);
        checkOutput("dec_s2", bus.out_s2, 5);
        checkOutput("dec_d1", bus.out_d1, 3);
        checkOutput("dec_level", level, 1);
        applyStimulus(0, 0, 1, 0);
        checkOutput("pop_level", level, 0);
        checkOutput("pop_valid", bus.out_valid, 0);
        checkOutput("pop_op_zero", bus.out_op, 0);

        // Fill past capacity with the consumer stalled
        for (int i = 0; i < 9; i++) begin
            checkOutput("fill_ready", bus.in_ready, (i < 8) ? 1 : 0);
            applyStimulus(1, i, 0, 0);
        end
        checkOutput("full_level", level, 8);
        checkOutput("full_ready", bus.in_ready, 0);
        for (int k = 0; k < 9; k++) begin
            checkOutput("drain_valid", bus.out_valid, 1);
            checkOutput("drain_head", bus.out_d1, k);
            if (k == 0) checkOutput("full_pop_ready", bus.in_ready, 0);
            if (k == 1) checkOutput("after_pop_ready", bus.in_ready, 1);
            applyStimulus((k <= 1) ? 1'b1 : 1'b0, 8, 1, 0);
            if (k == 0) checkOutput("after_pop_level", level, 7);
            if (k == 1) checkOutput("push_pop_level", level, 7);
        end
        checkOutput("drained_level", level, 0);
        checkOutput("drained_valid", bus.out_valid, 0);

        // Streaming push and pop across pointer wrap
        for (int j = 1; j <= 20; j++) begin
            if (j > 1) checkOutput("stream_head", bus.out_d1, j - 1);
            applyStimulus(1, j, 1, 0);
            checkOutput("stream_level", level, 1);
        end
        checkOutput("stream_last", bus.out_d1, 20);
        applyStimulus(0, 0, 1, 0);
        checkOutput("stream_end_level", level, 0);

        // Flush wins over a same-cycle push
        for (int i = 0; i < 5; i++) applyStimulus(1, 32'h10 + i, 0, 0);
        checkOutput("preflush_level", level, 5);
        applyStimulus(1, 32'h55, 0, 1);
        checkOutput("flush_level", level, 0);
        checkOutput("flush_valid", bus.out_valid, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("flush_idle_level", level, 0);
        applyStimulus(1, 32'h21, 0, 0);
        checkOutput("postflush_head", bus.out_d1, 32'h21);
        checkOutput("postflush_level", level, 1);
        applyStimulus(0, 0, 1, 0);
        checkOutput("postflush_empty", level, 0);

`ifdef CIM_ADDR_CHECK_EN
        applyStimulus(1, mk(5'd2, 9'd400, 9'd0, 9'd0), 0, 0);
        checkOutput("bad_err_addr", err_addr, 1);
        checkOutput("bad_err_count", err_count, 1);
        checkOutput("bad_level", level, 0);
        checkOutput("bad_valid", bus.out_valid, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("bad_pulse_end", err_addr, 0);
        applyStimulus(1, mk(5'd3, 9'd383, 9'd7, 9'd9), 0, 0);
        checkOutput("edge_level", level, 1);
        checkOutput("edge_s1", bus.out_s1, 383);
        checkOutput("edge_op", bus.out_op, 3);
        checkOutput("edge_err_addr", err_addr, 0);
        checkOutput("edge_err_count", err_count, 1);
        applyStimulus(0, 0, 1, 0);
`else
        applyStimulus(1, mk(5'd2, 9'd400, 9'd0, 9'd0), 0, 0);
        checkOutput("nochk_level", level, 1);
        checkOutput("nochk_s1", bus.out_s1, 400);
        checkOutput("nochk_err_addr", err_addr, 0);
        applyStimulus(0, 0, 1, 0);
        checkOutput("nochk_err_count", err_count, 0);
`endif

        // Asynchronous reset in the middle of a drain
        for (int i = 0; i < 4; i++) applyStimulus(1, 32'h30 + i, 0, 0);
        applyStimulus(0, 0, 1, 0);
        checkOutput("mid_level", level, 3);
        checkOutput("mid_head", bus.out_d1, 32'h31);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_valid", bus.out_valid, 0);
        checkOutput("async_level", level, 0);
        checkOutput("async_in_ready", bus.in_ready, 0);
        checkOutput("async_d1", bus.out_d1, 0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0);
        checkOutput("rerel_level", level, 0);
        checkOutput("rerel_in_ready", bus.in_ready, 1);
        checkOutput("rerel_valid", bus.out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
